// File: rtl/d_cache_pkg.sv
// Shared encodings for the direct-mapped write-through data cache.
// Optional KSEG1 uncached window is enabled by DCACHE_KSEG1_BYPASS_EN.
package d_cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2,
    BYPASS = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [2:0] KSEG1_HI  = 3'b101;

endpackage

// File: rtl/d_cache_data_ram.sv
// Line data storage: one 32-bit word per {index, word offset}, async read,
// byte-enable synchronous write.
module d_cache_data_ram #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    wbe,
  input  logic [31:0]   wdata
);

  logic [31:0] mem [2**AW];

  assign rdata = mem[raddr];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/d_cache_line.sv
// Direct-mapped, write-through, no-write-allocate data cache with multi-word lines.
// Build option DCACHE_KSEG1_BYPASS_EN makes p_a[31:29] == 3'b101 uncached.
//
//   state  | meaning
//   IDLE   | accept requests; read hits complete combinationally
//   REFILL | fetch a whole line, one word per m_ready beat
//   WRITE  | write-through to memory, merge into the line on a hit
//   BYPASS | single-beat uncached read (only with the bypass option)
module d_cache_line
  import d_cache_pkg::*;
#(
  parameter int A_WIDTH  = 32,
  parameter int C_INDEX  = 6,
  parameter int C_OFFSET = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [A_WIDTH-1:0] p_a,
  input  logic [31:0]        p_dout,
  output logic [31:0]        p_din,
  input  logic               p_strobe,
  input  logic [3:0]         p_wen,
  input  logic [1:0]         p_size,
  input  logic               p_rw,
  output logic               p_ready,
  output logic [A_WIDTH-1:0] m_a,
  input  logic [31:0]        m_dout,
  output logic [31:0]        m_din,
  output logic               m_strobe,
  output logic [3:0]         m_wen,
  output logic [1:0]         m_size,
  output logic               m_rw,
  input  logic               m_ready
);

  localparam int T_WIDTH = A_WIDTH - C_INDEX - C_OFFSET - 2;
  localparam int LINES   = 2**C_INDEX;
  localparam int RAW     = C_INDEX + C_OFFSET;

  state_t state, state_nx;

  logic [T_WIDTH-1:0] tag;
  logic [C_INDEX-1:0] index;
  logic [RAW-1:0]     p_word;
  logic [T_WIDTH-1:0] tags [LINES];
  logic [LINES-1:0]   valid;
  logic               hit;
  logic               bypass;

  logic [RAW-1:0]     refill_word;
  logic [A_WIDTH-1:0] refill_a;
  logic               last_beat;
  logic               cnt_inc;
  logic               miss_start;
  logic               line_done;

  logic               ram_we;
  logic [RAW-1:0]     ram_waddr;
  logic [3:0]         ram_wbe;
  logic [31:0]        ram_wdata;
  logic [31:0]        ram_rdata;

  assign tag    = p_a[A_WIDTH-1 -: T_WIDTH];
  assign index  = p_a[C_OFFSET+2 +: C_INDEX];
  assign p_word = p_a[2 +: RAW];
  assign hit    = valid[index] && (tags[index] == tag);

`ifdef DCACHE_KSEG1_BYPASS_EN
  assign bypass = (p_a[31:29] == KSEG1_HI);
`else
  assign bypass = 1'b0;
`endif

  generate
    if (C_OFFSET > 0) begin : g_cnt
      logic [C_OFFSET-1:0] cnt;
      always_ff @(posedge clk) begin
        if (rst)          cnt <= '0;
        else if (cnt_inc) cnt <= cnt + 1'b1;
      end
      assign refill_word = {index, cnt};
      assign refill_a    = {tag, index, cnt, 2'b00};
      assign last_beat   = (cnt == {C_OFFSET{1'b1}});
    end else begin : g_no_cnt
      assign refill_word = index;
      assign refill_a    = {tag, index, 2'b00};
      assign last_beat   = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      valid <= '0;
    end else begin
      state <= state_nx;
      if (miss_start) valid[index] <= 1'b0;
      if (line_done)  valid[index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (line_done) tags[index] <= tag;
  end

  always_comb begin
    state_nx   = state;
    p_ready    = 1'b0;
    p_din      = ram_rdata;
    m_strobe   = 1'b0;
    m_a        = p_a;
    m_din      = p_dout;
    m_wen      = 4'b0000;
    m_size     = p_size;
    m_rw       = 1'b0;
    ram_we     = 1'b0;
    ram_waddr  = p_word;
    ram_wbe    = 4'b0000;
    ram_wdata  = p_dout;
    cnt_inc    = 1'b0;
    miss_start = 1'b0;
    line_done  = 1'b0;
    case (state)
      IDLE: begin
        if (p_strobe) begin
          if (p_rw) begin
            state_nx = WRITE;
          end else if (bypass) begin
            state_nx = BYPASS;
          end else if (hit) begin
            p_ready = 1'b1;
          end else begin
            state_nx   = REFILL;
            miss_start = 1'b1;
          end
        end
      end
      REFILL: begin
        m_strobe = 1'b1;
        m_a      = refill_a;
        m_size   = SIZE_WORD;
        if (m_ready) begin
          ram_we    = 1'b1;
          ram_waddr = refill_word;
          ram_wbe   = 4'b1111;
          ram_wdata = m_dout;
          cnt_inc   = 1'b1;
          if (last_beat) begin
            line_done = 1'b1;
            state_nx  = IDLE;
          end
        end
      end
      WRITE: begin
        m_strobe = 1'b1;
        m_rw     = 1'b1;
        m_wen    = p_wen;
        if (m_ready) begin
          p_ready  = 1'b1;
          state_nx = IDLE;
          // uncached addresses never touch the line even if the tag happens to match
          if (hit && !bypass) begin
            ram_we  = 1'b1;
            ram_wbe = p_wen;
          end
        end
      end
`ifdef DCACHE_KSEG1_BYPASS_EN
      BYPASS: begin
        m_strobe = 1'b1;
        p_din    = m_dout;
        p_ready  = m_ready;
        if (m_ready) state_nx = IDLE;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  // a beat landing on the reset edge is dropped so the abandoned line stays inert
  d_cache_data_ram #(.AW(RAW)) u_data_ram (
    .clk   (clk),
    .raddr (p_word),
    .rdata (ram_rdata),
    .we    (ram_we & ~rst),
    .waddr (ram_waddr),
    .wbe   (ram_wbe),
    .wdata (ram_wdata)
  );

endmodule

// File: tb/tb_d_cache_line.sv
// Self-checking bench for d_cache_line: vector table plus reset/stray-beat/bypass sequences.
module tb_d_cache_line;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] p_a, p_dout, p_din, m_a, m_dout, m_din;
  logic        p_strobe, p_rw, p_ready, m_strobe, m_rw, m_ready;
  logic [3:0]  p_wen, m_wen;
  logic [1:0]  p_size, m_size;

  always #5 clk = ~clk;

  d_cache_line dut (
    .clk(clk), .rst(rst),
    .p_a(p_a), .p_dout(p_dout), .p_din(p_din), .p_strobe(p_strobe),
    .p_wen(p_wen), .p_size(p_size), .p_rw(p_rw), .p_ready(p_ready),
    .m_a(m_a), .m_dout(m_dout), .m_din(m_din), .m_strobe(m_strobe),
    .m_wen(m_wen), .m_size(m_size), .m_rw(m_rw), .m_ready(m_ready)
  );

  typedef struct {
    logic [31:0] a;
    logic        rw;
    logic [1:0]  size;
    logic [3:0]  wen;
  } beat_t;

  typedef struct {
    logic [31:0] a;
    logic        rw;
    logic [3:0]  wen;
    logic [31:0] wdata;
    logic [31:0] exp_din;
    int          beats;
    int          lat;
  } vec_t;

  beat_t       beat_log [$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_q [$];
  logic        stray_req;
  logic [31:0] mem_w;
  int          errors = 0;
  int          checks = 0;
  vec_t        vecs [15];

  function automatic logic [31:0] mem_default(input logic [31:0] a);
    if (a[31:4] == 28'h1) return 32'hA0 + 32'(a[3:2]);
    return 32'hC000_0000 | a;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return mem_default(a);
  endfunction

  // zero-wait memory: answers every strobed beat in the same cycle
  initial begin
    m_ready = 1'b0;
    m_dout  = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        m_ready = 1'b0;
      end else if (m_strobe) begin
        beat_log.push_back('{m_a, m_rw, m_size, m_wen});
        if (m_rw) begin
          mem_w = mem_rd({m_a[31:2], 2'b00});
          for (int b = 0; b < 4; b++)
            if (m_wen[b]) mem_w[8*b +: 8] = m_din[8*b +: 8];
          mem[{m_a[31:2], 2'b00}] = mem_w;
        end else begin
          m_dout = mem_rd({m_a[31:2], 2'b00});
        end
        m_ready = 1'b1;
      end else if (stray_req) begin
        m_dout  = 32'h0BAD_0BAD;
        m_ready = 1'b1;
      end else begin
        m_ready = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cpu_access(input string name, input logic [31:0] a, input logic rw,
                            input logic [3:0] wen, input logic [31:0] wdata,
                            input logic [1:0] size, input logic [31:0] exp_din,
                            input int exp_beats, input int exp_lat,
                            input logic [1:0] exp_size);
    int          base, lat, nb;
    bit          done;
    logic [31:0] got, want, ea;
    @(posedge clk);
    #1;
    base = beat_log.size();
    if (!rw) exp_q.push_back(exp_din);
    p_a = a; p_rw = rw; p_wen = wen; p_dout = wdata; p_size = size; p_strobe = 1'b1;
    lat  = 0;
    done = 1'b0;
    while (!done && lat <= 40) begin
      @(negedge clk);
      if (p_ready) done = 1'b1;
      else lat++;
    end
    got = p_din;
    @(posedge clk);
    #1;
    p_strobe = 1'b0;
    want = rw ? 32'h0 : exp_q.pop_front();
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no p_ready within %0d cycles, expected %0d", name, lat, exp_lat);
    end else begin
      check({name, " latency"}, 32'(lat), 32'(exp_lat));
      if (!rw) check({name, " p_din"}, got, want);
    end
    nb = beat_log.size() - base;
    check({name, " beats"}, 32'(nb), 32'(exp_beats));
    for (int k = 0; k < exp_beats && k < nb; k++) begin
      ea = (exp_beats > 1) ? ({a[31:4], 4'h0} + 32'(4*k)) : a;
      check($sformatf("%s beat%0d m_a", name, k), beat_log[base+k].a, ea);
      check($sformatf("%s beat%0d m_rw", name, k), 32'(beat_log[base+k].rw), 32'(rw));
      check($sformatf("%s beat%0d m_size", name, k), 32'(beat_log[base+k].size), 32'(exp_size));
      check($sformatf("%s beat%0d m_wen", name, k), 32'(beat_log[base+k].wen),
            rw ? 32'(wen) : 32'h0);
    end
  endtask

  initial begin
    int  base;
    bit  got_it;

    vecs[0]  = '{32'h0000_0010, 1'b0, 4'h0, 32'h0,         32'h0000_00A0, 4, 5};
    vecs[1]  = '{32'h0000_0018, 1'b0, 4'h0, 32'h0,         32'h0000_00A2, 0, 0};
    vecs[2]  = '{32'h0000_0014, 1'b1, 4'h3, 32'h1234_5678, 32'h0,         1, 1};
    vecs[3]  = '{32'h0000_0014, 1'b0, 4'h0, 32'h0,         32'h0000_5678, 0, 0};
    vecs[4]  = '{32'h0000_1000, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0,         1, 1};
    vecs[5]  = '{32'h0000_1000, 1'b0, 4'h0, 32'h0,         32'hDEAD_BEEF, 4, 5};
    vecs[6]  = '{32'h0000_1000, 1'b0, 4'h0, 32'h0,         32'hDEAD_BEEF, 0, 0};
    vecs[7]  = '{32'h0000_0410, 1'b0, 4'h0, 32'h0,         32'hC000_0410, 4, 5};
    vecs[8]  = '{32'h0000_0010, 1'b0, 4'h0, 32'h0,         32'h0000_00A0, 4, 5};
    vecs[9]  = '{32'h0000_0014, 1'b0, 4'h0, 32'h0,         32'h0000_5678, 0, 0};
    vecs[10] = '{32'h0000_0018, 1'b1, 4'h0, 32'hFFFF_FFFF, 32'h0,         1, 1};
    vecs[11] = '{32'h0000_0018, 1'b0, 4'h0, 32'h0,         32'h0000_00A2, 0, 0};
    vecs[12] = '{32'h0000_001C, 1'b1, 4'hC, 32'hAABB_CCDD, 32'h0,         1, 1};
    vecs[13] = '{32'h0000_001C, 1'b0, 4'h0, 32'h0,         32'hAABB_00A3, 0, 0};
    vecs[14] = '{32'h0000_1008, 1'b0, 4'h0, 32'h0,         32'hC000_1008, 0, 0};

    rst = 1'b1; stray_req = 1'b0;
    p_a = 32'h0; p_dout = 32'h0; p_strobe = 1'b0; p_wen = 4'h0; p_size = 2'b00; p_rw = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset p_ready", 32'(p_ready), 32'h0);
    check("reset m_strobe", 32'(m_strobe), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post-reset m_strobe", 32'(m_strobe), 32'h0);

    for (int i = 0; i < 15; i++)
      cpu_access($sformatf("vec%0d", i), vecs[i].a, vecs[i].rw, vecs[i].wen, vecs[i].wdata,
                 vecs[i].rw ? 2'b01 : 2'b00, vecs[i].exp_din, vecs[i].beats, vecs[i].lat,
                 vecs[i].rw ? 2'b01 : 2'b10);

    // stray m_ready while idle must do nothing
    @(posedge clk);
    #1 stray_req = 1'b1;
    @(negedge clk);
    check("stray p_ready", 32'(p_ready), 32'h0);
    check("stray m_strobe", 32'(m_strobe), 32'h0);
    stray_req = 1'b0;
    @(negedge clk);
    check("stray after m_strobe", 32'(m_strobe), 32'h0);
    cpu_access("stray hit", 32'h0000_0010, 1'b0, 4'h0, 32'h0, 2'b00, 32'h0000_00A0, 0, 0, 2'b10);

    // reset on the second beat of a refill
    @(posedge clk);
    #1;
    base = beat_log.size();
    p_a = 32'h0000_2000; p_rw = 1'b0; p_size = 2'b00; p_strobe = 1'b1;
    got_it = 1'b0;
    for (int i = 0; i < 40 && !got_it; i++) begin
      @(negedge clk);
      if (m_ready && (beat_log.size() - base == 2)) got_it = 1'b1;
    end
    if (!got_it) begin
      checks++;
      errors++;
      $display("FAIL rst-refill: beat 2 not seen, got %0d beats, expected 2", beat_log.size() - base);
    end
    rst = 1'b1;
    @(negedge clk);
    check("rst-refill m_strobe", 32'(m_strobe), 32'h0);
    check("rst-refill p_ready", 32'(p_ready), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0; p_strobe = 1'b0;
    @(negedge clk);
    check("rst-refill beats absorbed", 32'(beat_log.size() - base), 32'h2);
    cpu_access("rst re-read", 32'h0000_2000, 1'b0, 4'h0, 32'h0, 2'b00, 32'hC000_2000, 4, 5, 2'b10);
    cpu_access("rst valid cleared", 32'h0000_001C, 1'b0, 4'h0, 32'h0, 2'b00, 32'hAABB_00A3, 4, 5, 2'b10);

`ifdef DCACHE_KSEG1_BYPASS_EN
    cpu_access("kseg1 rd1", 32'hA000_0000, 1'b0, 4'h0, 32'h0, 2'b00, 32'hE000_0000, 1, 1, 2'b00);
    cpu_access("kseg1 rd2", 32'hA000_0000, 1'b0, 4'h0, 32'h0, 2'b00, 32'hE000_0000, 1, 1, 2'b00);
`else
    cpu_access("kseg1 rd1", 32'hA000_0000, 1'b0, 4'h0, 32'h0, 2'b00, 32'hE000_0000, 4, 5, 2'b10);
    cpu_access("kseg1 rd2", 32'hA000_0000, 1'b0, 4'h0, 32'h0, 2'b00, 32'hE000_0000, 0, 0, 2'b10);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
